// File: rtl/trdb_pkg.sv
// Shared types and widths for the trace-encoder packet scheduler.
package trdb_pkg;

  localparam int unsigned PC_LEN       = 32;
  localparam int unsigned PAYLOAD_LEN  = 32;
  localparam int unsigned CAUSE_LEN    = 5;
  localparam int unsigned PRIV_LEN     = 2;
  localparam int unsigned RESYNC_CNT_W = 16;

  typedef enum logic [1:0] {
    F_OPT_EXT    = 2'd0,
    F_DIFF_DELTA = 2'd1,
    F_ADDR_ONLY  = 2'd2,
    F_SYNC       = 2'd3
  } trdb_format_e;

  typedef enum logic [1:0] {
    SF_START   = 2'd0,
    SF_TRAP    = 2'd1,
    SF_CONTEXT = 2'd2,
    SF_SUPPORT = 2'd3
  } trdb_sync_subformat_e;

  typedef enum logic [1:0] {
    SF_PBC = 2'd0,
    SF_JTC = 2'd1
  } trdb_ext_subformat_e;

  typedef enum logic [1:0] {IDLE, START, RUN, DRAIN} trdb_sched_state_e;

  typedef enum logic {CYCLE_MODE, PACKET_MODE} trdb_resync_mode_e;

  typedef struct packed {
    trdb_format_e             format;
    logic [1:0]               subformat;
    logic [PAYLOAD_LEN-1:0]   payload;
    logic [CAUSE_LEN-1:0]     cause;
    logic [PRIV_LEN-1:0]      priv;
  } trdb_pkt_t;

  // Sync packet skeleton; cause/priv filled in by the caller where relevant.
  function automatic trdb_pkt_t sync_pkt(input trdb_sync_subformat_e sf,
                                         input logic [PAYLOAD_LEN-1:0] payload);
    trdb_pkt_t p;
    p           = '0;
    p.format    = F_SYNC;
    p.subformat = sf;
    p.payload   = payload;
    return p;
  endfunction

endpackage

// File: rtl/trdb_resync_counter.sv
// Resync interval counter: saturating count of RUN cycles or emitted non-sync packets,
// raising a sticky pending flag at the terminal value.
module trdb_resync_counter
  import trdb_pkg::*;
#(
  parameter trdb_resync_mode_e MODE = CYCLE_MODE,
  parameter int unsigned       MAX  = 1023
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic run_i,
  input  logic pkt_i,
  input  logic clear_i,
  output logic pending_o
);

  localparam logic [RESYNC_CNT_W-1:0] Terminal = RESYNC_CNT_W'(MAX);

  logic [RESYNC_CNT_W-1:0] count;
  logic [RESYNC_CNT_W-1:0] count_next;
  logic                    inc;

  always_comb begin
    inc        = (MODE == CYCLE_MODE) ? run_i : pkt_i;
    count_next = count;
    if (inc && (count != Terminal)) count_next = count + RESYNC_CNT_W'(1);
  end

  // A sync grant wins over any same-cycle increment.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count     <= '0;
      pending_o <= 1'b0;
    end else if (clear_i) begin
      count     <= '0;
      pending_o <= 1'b0;
    end else begin
      count <= count_next;
      if (count_next == Terminal) pending_o <= 1'b1;
    end
  end

endmodule

// File: rtl/trdb_packet_scheduler.sv
// Arbitrates trace-encoder packet requests onto the single packet-emitter datapath
// through a one-entry registered output slot with valid/ready handshake.
module trdb_packet_scheduler
  import trdb_pkg::*;
#(
  parameter trdb_resync_mode_e RESYNC_MODE = CYCLE_MODE,
  parameter int unsigned       RESYNC_MAX  = 1023
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   enable_i,
  input  logic [PC_LEN-1:0]      pc_i,
  input  logic                   trap_valid_i,
  input  logic [CAUSE_LEN-1:0]   trap_cause_i,
  input  logic [PC_LEN-1:0]      trap_addr_i,
  output logic                   trap_ready_o,
  input  logic                   ctx_valid_i,
  input  logic [PRIV_LEN-1:0]    ctx_priv_i,
  output logic                   ctx_ready_o,
  input  logic                   addr_valid_i,
  input  logic [PAYLOAD_LEN-1:0] addr_i,
  output logic                   addr_ready_o,
  input  logic                   diff_valid_i,
  input  logic [PAYLOAD_LEN-1:0] diff_i,
  output logic                   diff_ready_o,
  input  logic                   pbc_valid_i,
  input  logic [PAYLOAD_LEN-1:0] pbc_i,
  output logic                   pbc_ready_o,
  output logic                   pkt_valid_o,
  input  logic                   pkt_ready_i,
  output logic [1:0]             pkt_format_o,
  output logic [1:0]             pkt_subformat_o,
  output logic [PAYLOAD_LEN-1:0] pkt_payload_o,
  output logic [CAUSE_LEN-1:0]   pkt_cause_o,
  output logic [PRIV_LEN-1:0]    pkt_priv_o,
  output logic                   resync_pending_o
);

  trdb_sched_state_e state;
  trdb_pkt_t         pkt_q;
  trdb_pkt_t         pkt_next;

  logic slot_free, run_grant, hi_req, lo_block;
  logic start_grant, resync_grant, sync_grant, nonsync_grant, grant;

  assign slot_free   = !pkt_valid_o || pkt_ready_i;
  assign run_grant   = (state == RUN) && enable_i && slot_free;
  assign start_grant = (state == START) && enable_i && slot_free;
  assign hi_req      = trap_valid_i || ctx_valid_i;
  // A due resync holds off the low-priority sources until it goes out.
  assign lo_block    = hi_req || resync_pending_o;

  assign trap_ready_o = run_grant && trap_valid_i;
  assign ctx_ready_o  = run_grant && ctx_valid_i && !trap_valid_i;
  assign resync_grant = run_grant && resync_pending_o && !hi_req;
  assign addr_ready_o = run_grant && !lo_block && addr_valid_i;
  assign diff_ready_o = run_grant && !lo_block && !addr_valid_i && diff_valid_i;
  assign pbc_ready_o  = run_grant && !lo_block && !addr_valid_i && !diff_valid_i && pbc_valid_i;

  assign sync_grant    = start_grant || trap_ready_o || ctx_ready_o || resync_grant;
  assign nonsync_grant = addr_ready_o || diff_ready_o || pbc_ready_o;
  assign grant         = sync_grant || nonsync_grant;

  // Payload selection for whichever source wins this cycle.
  always_comb begin
    pkt_next = '0;
    if (start_grant || resync_grant) begin
      pkt_next = sync_pkt(SF_START, PAYLOAD_LEN'(pc_i));
    end else if (trap_ready_o) begin
      pkt_next       = sync_pkt(SF_TRAP, PAYLOAD_LEN'(trap_addr_i));
      pkt_next.cause = trap_cause_i;
    end else if (ctx_ready_o) begin
      pkt_next      = sync_pkt(SF_CONTEXT, '0);
      pkt_next.priv = ctx_priv_i;
    end else if (addr_ready_o) begin
      pkt_next.format  = F_ADDR_ONLY;
      pkt_next.payload = addr_i;
    end else if (diff_ready_o) begin
      pkt_next.format  = F_DIFF_DELTA;
      pkt_next.payload = diff_i;
    end else if (pbc_ready_o) begin
      pkt_next.format    = F_OPT_EXT;
      pkt_next.subformat = SF_PBC;
      pkt_next.payload   = pbc_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      pkt_valid_o <= 1'b0;
      pkt_q       <= '0;
    end else begin
      if (grant) begin
        pkt_q       <= pkt_next;
        pkt_valid_o <= 1'b1;
      end else if (pkt_ready_i) begin
        pkt_valid_o <= 1'b0;
      end
      case (state)
        IDLE:    if (enable_i) state <= START;
        START:   if (!enable_i) state <= IDLE;
                 else if (slot_free) state <= RUN;
        RUN:     if (!enable_i) state <= DRAIN;
        DRAIN:   if (!pkt_valid_o || pkt_ready_i) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign pkt_format_o    = pkt_q.format;
  assign pkt_subformat_o = pkt_q.subformat;
  assign pkt_payload_o   = pkt_q.payload;
  assign pkt_cause_o     = pkt_q.cause;
  assign pkt_priv_o      = pkt_q.priv;

  trdb_resync_counter #(
    .MODE (RESYNC_MODE),
    .MAX  (RESYNC_MAX)
  ) u_resync (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .run_i     (state == RUN),
    .pkt_i     (nonsync_grant),
    .clear_i   (sync_grant),
    .pending_o (resync_pending_o)
  );

endmodule

// File: tb/tb_trdb_packet_scheduler.sv
// Randomized scoreboard bench for trdb_packet_scheduler against a cycle-level reference model.
module tb_trdb_packet_scheduler;
  import trdb_pkg::*;

  localparam int unsigned RMAX = 4;
  localparam int P_IDLE = 0, P_START = 1, P_RUN = 2, P_DRAIN = 3;

  logic                   clk_i = 1'b0;
  logic                   rst_i = 1'b1;
  logic                   enable_i = 1'b0;
  logic [PC_LEN-1:0]      pc_i = '0;
  logic                   trap_valid_i = 1'b0;
  logic [CAUSE_LEN-1:0]   trap_cause_i = '0;
  logic [PC_LEN-1:0]      trap_addr_i = '0;
  logic                   trap_ready_o;
  logic                   ctx_valid_i = 1'b0;
  logic [PRIV_LEN-1:0]    ctx_priv_i = '0;
  logic                   ctx_ready_o;
  logic                   addr_valid_i = 1'b0;
  logic [PAYLOAD_LEN-1:0] addr_i = '0;
  logic                   addr_ready_o;
  logic                   diff_valid_i = 1'b0;
  logic [PAYLOAD_LEN-1:0] diff_i = '0;
  logic                   diff_ready_o;
  logic                   pbc_valid_i = 1'b0;
  logic [PAYLOAD_LEN-1:0] pbc_i = '0;
  logic                   pbc_ready_o;
  logic                   pkt_valid_o;
  logic                   pkt_ready_i = 1'b0;
  logic [1:0]             pkt_format_o;
  logic [1:0]             pkt_subformat_o;
  logic [PAYLOAD_LEN-1:0] pkt_payload_o;
  logic [CAUSE_LEN-1:0]   pkt_cause_o;
  logic [PRIV_LEN-1:0]    pkt_priv_o;
  logic                   resync_pending_o;

  always #5 clk_i = ~clk_i;

  trdb_packet_scheduler #(.RESYNC_MODE(CYCLE_MODE), .RESYNC_MAX(RMAX)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i), .pc_i(pc_i),
    .trap_valid_i(trap_valid_i), .trap_cause_i(trap_cause_i), .trap_addr_i(trap_addr_i),
    .trap_ready_o(trap_ready_o),
    .ctx_valid_i(ctx_valid_i), .ctx_priv_i(ctx_priv_i), .ctx_ready_o(ctx_ready_o),
    .addr_valid_i(addr_valid_i), .addr_i(addr_i), .addr_ready_o(addr_ready_o),
    .diff_valid_i(diff_valid_i), .diff_i(diff_i), .diff_ready_o(diff_ready_o),
    .pbc_valid_i(pbc_valid_i), .pbc_i(pbc_i), .pbc_ready_o(pbc_ready_o),
    .pkt_valid_o(pkt_valid_o), .pkt_ready_i(pkt_ready_i),
    .pkt_format_o(pkt_format_o), .pkt_subformat_o(pkt_subformat_o),
    .pkt_payload_o(pkt_payload_o), .pkt_cause_o(pkt_cause_o), .pkt_priv_o(pkt_priv_o),
    .resync_pending_o(resync_pending_o)
  );

  typedef logic [63:0] word_t;

  word_t       sb[$];
  int          checks = 0;
  int          fails = 0;

  // Reference model state: protocol phase, RUN cycles since last sync, output slot occupancy.
  int          phase = P_IDLE;
  int unsigned since_sync = 0;
  bit          occ = 1'b0;
  bit          take_trap, take_ctx, take_addr, take_diff, take_pbc;
  bit          rand_pc = 1'b1;

  function automatic word_t mk(input logic [1:0] fmt, input logic [1:0] sub,
                               input logic [PAYLOAD_LEN-1:0] pay,
                               input logic [CAUSE_LEN-1:0] cause,
                               input logic [PRIV_LEN-1:0] priv);
    return word_t'({fmt, sub, pay, cause, priv});
  endfunction

  task automatic check(input string name, input word_t act, input word_t exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Predict this cycle's grant from the protocol rules, check readies, advance the model.
  task automatic model_step();
    bit    sf, g, sync;
    bit    et, ec, ea, ed, ep;
    word_t e;
    int    nphase;
    sf = !occ || pkt_ready_i;
    g = 0; sync = 0; et = 0; ec = 0; ea = 0; ed = 0; ep = 0; e = '0;
    nphase = phase;
    check("pending", word_t'(resync_pending_o), word_t'(since_sync >= RMAX));
    check("pkt_valid", word_t'(pkt_valid_o), word_t'(occ));
    case (phase)
      P_IDLE: if (enable_i) nphase = P_START;
      P_START: begin
        if (!enable_i) nphase = P_IDLE;
        else if (sf) begin
          g = 1; sync = 1; nphase = P_RUN;
          e = mk(F_SYNC, SF_START, PAYLOAD_LEN'(pc_i), '0, '0);
        end
      end
      P_RUN: begin
        if (!enable_i) nphase = P_DRAIN;
        else if (sf) begin
          if (trap_valid_i) begin
            et = 1; g = 1; sync = 1;
            e = mk(F_SYNC, SF_TRAP, PAYLOAD_LEN'(trap_addr_i), trap_cause_i, '0);
          end else if (ctx_valid_i) begin
            ec = 1; g = 1; sync = 1;
            e = mk(F_SYNC, SF_CONTEXT, '0, '0, ctx_priv_i);
          end else if (since_sync >= RMAX) begin
            g = 1; sync = 1;
            e = mk(F_SYNC, SF_START, PAYLOAD_LEN'(pc_i), '0, '0);
          end else if (addr_valid_i) begin
            ea = 1; g = 1; e = mk(F_ADDR_ONLY, 2'd0, addr_i, '0, '0);
          end else if (diff_valid_i) begin
            ed = 1; g = 1; e = mk(F_DIFF_DELTA, 2'd0, diff_i, '0, '0);
          end else if (pbc_valid_i) begin
            ep = 1; g = 1; e = mk(F_OPT_EXT, SF_PBC, pbc_i, '0, '0);
          end
        end
      end
      default: if (!occ || pkt_ready_i) nphase = P_IDLE;
    endcase
    if (sync) since_sync = 0;
    else if (phase == P_RUN) since_sync++;
    check("trap_ready", word_t'(trap_ready_o), word_t'(et));
    check("ctx_ready",  word_t'(ctx_ready_o),  word_t'(ec));
    check("addr_ready", word_t'(addr_ready_o), word_t'(ea));
    check("diff_ready", word_t'(diff_ready_o), word_t'(ed));
    check("pbc_ready",  word_t'(pbc_ready_o),  word_t'(ep));
    if (g) sb.push_back(e);
    occ = g ? 1'b1 : (pkt_ready_i ? 1'b0 : occ);
    take_trap = et; take_ctx = ec; take_addr = ea; take_diff = ed; take_pbc = ep;
    phase = nphase;
  endtask

  // One cycle: retire accepted requests, raise new ones, drive enable/ready, run the model.
  task automatic cycle_step(input bit en, input int lo_pct, input int hi_pct, input int rdy_pct);
    @(negedge clk_i);
    if (take_trap) trap_valid_i = 1'b0;
    if (take_ctx)  ctx_valid_i  = 1'b0;
    if (take_addr) addr_valid_i = 1'b0;
    if (take_diff) diff_valid_i = 1'b0;
    if (take_pbc)  pbc_valid_i  = 1'b0;
    if (!trap_valid_i && $urandom_range(99) < hi_pct) begin
      trap_valid_i = 1'b1; trap_cause_i = CAUSE_LEN'($urandom); trap_addr_i = PC_LEN'($urandom);
    end
    if (!ctx_valid_i && $urandom_range(99) < hi_pct) begin
      ctx_valid_i = 1'b1; ctx_priv_i = PRIV_LEN'($urandom);
    end
    if (!addr_valid_i && $urandom_range(99) < lo_pct) begin
      addr_valid_i = 1'b1; addr_i = PAYLOAD_LEN'($urandom);
    end
    if (!diff_valid_i && $urandom_range(99) < lo_pct) begin
      diff_valid_i = 1'b1; diff_i = PAYLOAD_LEN'($urandom);
    end
    if (!pbc_valid_i && $urandom_range(99) < lo_pct) begin
      pbc_valid_i = 1'b1; pbc_i = PAYLOAD_LEN'($urandom);
    end
    enable_i    = en;
    pc_i        = rand_pc ? PC_LEN'($urandom) : PC_LEN'(32'h100);
    pkt_ready_i = ($urandom_range(99) < rdy_pct);
    #1 model_step();
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    enable_i = 1'b0; pkt_ready_i = 1'b0;
    trap_valid_i = 1'b0; ctx_valid_i = 1'b0;
    addr_valid_i = 1'b0; diff_valid_i = 1'b0; pbc_valid_i = 1'b0;
    #1;
    check("rst_pkt_valid", word_t'(pkt_valid_o), '0);
    check("rst_pending", word_t'(resync_pending_o), '0);
    check("rst_format", word_t'(pkt_format_o), '0);
    sb.delete();
    phase = P_IDLE; since_sync = 0; occ = 1'b0;
    take_trap = 0; take_ctx = 0; take_addr = 0; take_diff = 0; take_pbc = 0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  // Monitor: pops the scoreboard on every handshake and checks stalled outputs stay put.
  initial begin
    word_t cur, held;
    bit    have;
    have = 1'b0;
    held = '0;
    forever begin
      @(negedge clk_i);
      #2;
      if (rst_i) begin
        have = 1'b0;
      end else begin
        cur = mk(pkt_format_o, pkt_subformat_o, pkt_payload_o, pkt_cause_o, pkt_priv_o);
        if (have) check("hold_stable", cur, held);
        if (pkt_valid_o && pkt_ready_i) begin
          if (sb.size() == 0) begin
            checks++; fails++;
            $display("FAIL unexpected_pkt: got %0h expected none at %0t", cur, $time);
          end else begin
            check("pkt", cur, sb.pop_front());
          end
        end
        have = pkt_valid_o && !pkt_ready_i;
        held = cur;
      end
    end
  end

  initial begin
    bit en;
    do_reset();

    // Enable with fixed PC and ready held high: start packet with payload 0x100.
    rand_pc = 1'b0;
    repeat (4) cycle_step(1, 0, 0, 100);
    check("start_seen", word_t'(sb.size()), '0);
    rand_pc = 1'b1;

    // Three low-priority requests at once, drained in priority order.
    cycle_step(1, 100, 0, 100);
    repeat (8) cycle_step(1, 0, 0, 100);

    // Idle until resync fires, then trap racing a pending resync.
    repeat (6) cycle_step(1, 0, 0, 100);
    cycle_step(1, 0, 100, 100);
    repeat (4) cycle_step(1, 0, 0, 100);

    // Downstream stalled with requests waiting, then released.
    repeat (6) cycle_step(1, 100, 50, 0);
    repeat (10) cycle_step(1, 0, 0, 100);

    // Enable dropped while a packet is held.
    repeat (3) cycle_step(1, 100, 0, 0);
    repeat (3) cycle_step(0, 0, 0, 0);
    repeat (4) cycle_step(0, 0, 0, 100);

    // Randomized traffic with occasional enable toggles and a mid-run reset.
    en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(99) == 0) en = ~en;
      if (i == 1500) begin
        do_reset();
        en = 1'b1;
      end
      cycle_step(en, 20, 4, 70);
    end

    repeat (12) cycle_step(0, 0, 0, 100);
    check("sb_empty", word_t'(sb.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
